// File: rtl/prog_mem_loadable_if.sv
// Fetch and program-load bundle for prog_mem_loadable.
// master drives requests and load words; slave is the memory.
interface prog_mem_loadable_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  rd_oor;
  logic                  prog_start;
  logic                  prog_valid;
  logic [DATA_WIDTH-1:0] prog_data;
  logic                  prog_last;
  logic                  prog_ready;
  logic                  busy;
  logic                  load_done;
  logic [ADDR_WIDTH-1:0] load_count;
  logic                  par_err;

  modport master (
    output rd_en, address, prog_start,
    output prog_valid, prog_data, prog_last,
    input  data_out, rd_valid, rd_oor,
    input  prog_ready, busy, load_done,
    input  load_count, par_err
  );

  modport slave (
    input  rd_en, address, prog_start,
    input  prog_valid, prog_data, prog_last,
    output data_out, rd_valid, rd_oor,
    output prog_ready, busy, load_done,
    output load_count, par_err
  );
endinterface

// File: rtl/prog_mem_loadable.sv
// Loadable program memory with registered fetch port.
// Optional even-parity storage/check: define PMEM_PARITY_EN.
module prog_mem_loadable #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 128
) (
  input logic clk,
  input logic reset,
  prog_mem_loadable_if.slave bus
);
`ifdef PMEM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_P =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {RUN, LOAD} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  oor_q, oor_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;
  logic                  we;
  logic                  in_range;
  logic [MW-1:0]         wr_word;
  logic [MW-1:0]         rd_word;
  logic [MW-1:0]         mem_q [DEPTH];

  assign in_range = {1'b0, bus.address} < DEPTH_W;
  assign rd_word  = mem_q[bus.address[IW-1:0]];
`ifdef PMEM_PARITY_EN
  assign wr_word  = {^bus.prog_data, bus.prog_data};
`else
  assign wr_word  = bus.prog_data;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    oor_d   = 1'b0;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.rd_en) begin
          if (in_range) begin
            data_d  = rd_word[DATA_WIDTH-1:0];
            valid_d = 1'b1;
`ifdef PMEM_PARITY_EN
            perr_d  = ^rd_word;
`endif
          end else begin
            oor_d = 1'b1;
          end
        end
        if (bus.prog_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bus.prog_valid) begin
          we    = 1'b1;
          ptr_d = ptr_q + 1'b1;
          cnt_d = ptr_q + 1'b1;
          // final word or last slot ends the load
          if (bus.prog_last || ptr_q == LAST_P) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      oor_q   <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      oor_q   <= oor_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  // array contents survive reset
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem_q[ptr_q[IW-1:0]] <= wr_word;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.rd_valid   = valid_q;
  assign bus.rd_oor     = oor_q;
  assign bus.prog_ready = (state_q == LOAD);
  assign bus.busy       = (state_q == LOAD);
  assign bus.load_done  = done_q;
  assign bus.load_count = cnt_q;
  assign bus.par_err    = perr_q;
endmodule

// File: tb/tb_prog_mem_loadable.sv
// Random/directed bench for prog_mem_loadable.
// Reference: array image plus load-session bookkeeping.
module tb_prog_mem_loadable;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_mem_loadable_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  prog_mem_loadable #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(128)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int ref_mem [128];
  bit known   [128];
  bit bad     [128];
  bit loading = 0;
  int ptr = 0;
  int exp_cnt = 0;
  int exp_data = 0;
  bit data_known = 1;
  bit exp_valid, exp_oor, exp_done, exp_perr;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int a;
    a = int'(bus.address);
    exp_valid = 0;
    exp_oor   = 0;
    exp_done  = 0;
    exp_perr  = 0;
    if (rst) begin
      loading = 0; ptr = 0; exp_cnt = 0;
      exp_data = 0; data_known = 1;
    end else if (!loading) begin
      if (bus.rd_en) begin
        if (a < 128) begin
          exp_valid  = 1;
          exp_data   = ref_mem[a];
          data_known = known[a];
          exp_perr   = bad[a];
        end else begin
          exp_oor = 1;
        end
      end
      if (bus.prog_start) begin
        loading = 1; ptr = 0; exp_cnt = 0;
      end
    end else if (bus.prog_valid) begin
      ref_mem[ptr] = int'(bus.prog_data);
      known[ptr] = 1;
      bad[ptr] = 0;
      ptr++;
      exp_cnt = ptr % 256;
      if (bus.prog_last || ptr == 128) begin
        loading = 0;
        exp_done = 1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
    check_eq("rd_oor", 32'(bus.rd_oor), 32'(exp_oor));
    check_eq("busy", 32'(bus.busy), 32'(loading));
    check_eq("prog_ready", 32'(bus.prog_ready), 32'(loading));
    check_eq("load_done", 32'(bus.load_done), 32'(exp_done));
    check_eq("load_count", 32'(bus.load_count), 32'(exp_cnt));
    if (data_known)
      check_eq("data_out", 32'(bus.data_out), 32'(exp_data));
`ifdef PMEM_PARITY_EN
    check_eq("par_err", 32'(bus.par_err), 32'(exp_perr));
`else
    check_eq("par_err", 32'(bus.par_err), 32'd0);
`endif
  endtask

  task automatic idle();
    bus.rd_en = 0; bus.address = '0;
    bus.prog_start = 0; bus.prog_valid = 0;
    bus.prog_data = '0; bus.prog_last = 0;
  endtask

  task automatic fetch(input int a);
    idle();
    bus.rd_en = 1;
    bus.address = 8'(a);
    tick();
  endtask

  task automatic load_image(input logic [7:0] img[$]);
    int i;
    idle();
    bus.prog_start = 1;
    tick();
    i = 0;
    while (i < img.size()) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        bus.prog_valid = 1;
        bus.prog_data = img[i];
        bus.prog_last = (i == img.size() - 1);
        i++;
      end
      tick();
    end
    idle();
    tick();
  endtask

  logic [7:0] img_a[$];
  logic [7:0] img_b[$];

  initial begin
    foreach (known[k]) begin
      known[k] = 0; bad[k] = 0; ref_mem[k] = 0;
    end
    img_a = '{8'h87, 8'hF0, 8'h88, 8'h0A,
              8'h42, 8'h96, 8'h82};
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();

    fetch(5);
    idle();
    tick();

    load_image(img_a);
    check_eq("t2_count", 32'(bus.load_count), 32'd7);
    for (int a = 0; a < 7; a++) fetch(a);
    for (int a = 6; a >= 0; a--) fetch(a);
    fetch(5);
    idle();
    tick();
    fetch(5);
    check_eq("t1_data5", 32'(bus.data_out), 32'h96);

    fetch(6);
    fetch(8'h80);
    fetch(8'hFF);
    check_eq("t3_hold", 32'(bus.data_out), 32'h82);

    idle();
    bus.prog_start = 1;
    tick();
    for (int i = 0; i < 130; i++) begin
      idle();
      bus.prog_valid = 1;
      bus.prog_data = 8'($urandom);
      bus.prog_start = (i == 20);
      tick();
    end
    check_eq("t4_count", 32'(bus.load_count), 32'h80);

    for (int i = 0; i < 60; i++) begin
      idle();
      bus.rd_en = 1'($urandom);
      bus.address = 8'($urandom_range(0, 255));
      bus.prog_valid = 1'($urandom);
      bus.prog_data = 8'($urandom);
      tick();
    end

    img_b.delete();
    for (int i = 0; i < 7; i++) img_b.push_back(8'($urandom));
    load_image(img_b);
    idle();
    bus.rd_en = 1;
    bus.address = 8'd2;
    bus.prog_start = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.rd_en = 1;
      bus.address = 8'($urandom_range(0, 6));
      bus.prog_valid = 1;
      bus.prog_data = 8'($urandom);
      tick();
    end
    idle();
    rst = 1;
    tick();
    rst = 0;
    tick();
    for (int a = 0; a < 7; a++) fetch(a);

`ifdef PMEM_PARITY_EN
    img_a = '{8'h42};
    load_image(img_a);
    dut.mem_q[0][0] = ~dut.mem_q[0][0];
    ref_mem[0] = ref_mem[0] ^ 1;
    bad[0] = 1;
    fetch(0);
    check_eq("t6_data", 32'(bus.data_out), 32'h43);
    fetch(1);
    fetch(0);
`endif

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
